// File: rtl/fa_cla_bist_pkg.sv
// Shared types and helpers for the fa_cla_bist adder self-test controller:
// FSM state encoding, LFSR tap mask, default seed and the golden adder model.
package fa_cla_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Feedback taps q15 ^ q13 ^ q12 ^ q10 of the 16-bit Fibonacci LFSR.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  // Golden {cout,sum} of a width-bit add/subtract. Subtraction is a + ~b + 1,
  // so the carry out is the "no borrow" flag. The result is masked to width+1
  // bits; callers narrow it with a size cast.
  function automatic logic [32:0] golden_result(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        sub,
    input logic        c_in,
    input int unsigned width
  );
    logic [32:0] mask;
    logic [32:0] b_eff;
    logic [32:0] sum;
    mask  = (33'd1 << width) - 33'd1;
    b_eff = sub ? ({1'b0, ~b} & mask) : ({1'b0, b} & mask);
    sum   = ({1'b0, a} & mask) + b_eff + (sub ? 33'd1 : {32'd0, c_in});
    return sum & ((33'd1 << (width + 32'd1)) - 33'd1);
  endfunction

endpackage

// File: rtl/fa_cla_bist_if.sv
// Operand/result bus between the self-test controller (master) and the
// carry-lookahead adder under test (slave).
interface fa_cla_bist_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (output a, output b, output sub, output c_in,
                  input dut_sum, input dut_cout);
  modport slave  (input a, input b, input sub, input c_in,
                  output dut_sum, output dut_cout);
endinterface

// File: rtl/fa_cla_bist_lfsr.sv
// Fibonacci LFSR used as the operand source: shifts left, XOR of the tapped
// bits enters at bit 0. load reloads the seed and has priority over step.
module fa_cla_bist_lfsr
  import fa_cla_bist_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS),
  parameter logic [W-1:0] SEED = W'(DEFAULT_LFSR_SEED)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] q
);

  // LFSR state register: reset/load to the seed, otherwise advance on step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[W-2:0], ^(q & TAPS)};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/fa_cla_bist.sv
// Built-in self-test controller for the 8-bit carry-lookahead adder/subtractor.
// Drives LFSR operands onto the adder bus, waits a settle window, compares the
// adder's {cout,sum} with an internal golden result and counts mismatches.
// Optional build macro FA_CLA_BIST_FIRST_FAIL_EN adds first-failure capture
// outputs (fail_valid, fail_a, fail_b, fail_sub, fail_cin, fail_index).
module fa_cla_bist
  import fa_cla_bist_pkg::*;
#(
  parameter int          WIDTH         = 8,
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = DEFAULT_LFSR_SEED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  fa_cla_bist_if.master       adder,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          err_count
`ifdef FA_CLA_BIST_FIRST_FAIL_EN
  ,
  output logic                fail_valid,
  output logic [WIDTH-1:0]    fail_a,
  output logic [WIDTH-1:0]    fail_b,
  output logic                fail_sub,
  output logic                fail_cin,
  output logic [15:0]         fail_index
`endif
);

  localparam int          LW          = 2 * WIDTH;
  localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [LW-1:0]    lfsr_q;
  logic [15:0]      index;
  logic [15:0]      settle_cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             cin_q;
  logic [WIDTH:0]   expected;

  logic             load_s;
  logic             step_s;
  logic             mismatch_s;
  logic             sub_next_s;
  logic             cin_next_s;
  logic [WIDTH:0]   gold_s;

  // A run starts only from IDLE or DONE; start during a run is ignored.
  assign load_s     = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign step_s     = (state == ST_CHECK);
  assign sub_next_s = index[0];
  assign cin_next_s = index[1] & ~index[0];
  assign gold_s     = (WIDTH + 1)'(golden_result(32'(lfsr_q[LW-1:WIDTH]),
                                                 32'(lfsr_q[WIDTH-1:0]),
                                                 sub_next_s, cin_next_s,
                                                 WIDTH));
  assign mismatch_s = ({adder.dut_cout, adder.dut_sum} != expected);

  assign adder.a    = a_q;
  assign adder.b    = b_q;
  assign adder.sub  = sub_q;
  assign adder.c_in = cin_q;

  fa_cla_bist_lfsr #(
    .W    (LW),
    .TAPS (LW'(LFSR_TAPS)),
    .SEED (LW'(LFSR_SEED))
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .step  (step_s),
    .q     (lfsr_q)
  );

  // Run sequencer: operand drive, settle wait, compare/count and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      index      <= 16'd0;
      settle_cnt <= 16'd0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      cin_q      <= 1'b0;
      expected   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
`ifdef FA_CLA_BIST_FIRST_FAIL_EN
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_sub   <= 1'b0;
      fail_cin   <= 1'b0;
      fail_index <= 16'd0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Operands keep the last vector until a new run starts.
          if (start) begin
            state     <= ST_DRIVE;
            index     <= 16'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'd0;
`ifdef FA_CLA_BIST_FIRST_FAIL_EN
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_sub   <= 1'b0;
            fail_cin   <= 1'b0;
            fail_index <= 16'd0;
`endif
          end else begin
            state <= state;
          end
        end
        ST_DRIVE: begin
          a_q        <= lfsr_q[LW-1:WIDTH];
          b_q        <= lfsr_q[WIDTH-1:0];
          sub_q      <= sub_next_s;
          cin_q      <= cin_next_s;
          expected   <= gold_s;
          settle_cnt <= 16'd0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        ST_CHECK: begin
          // Count failing vectors, not failing bits; never wrap past 255.
          if (mismatch_s && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
          end
`ifdef FA_CLA_BIST_FIRST_FAIL_EN
          if (mismatch_s && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= a_q;
            fail_b     <= b_q;
            fail_sub   <= sub_q;
            fail_cin   <= cin_q;
            fail_index <= index;
          end
`endif
          if (index == LAST_IDX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 8'd0) && !mismatch_s;
          end else begin
            index <= index + 16'd1;
            state <= ST_DRIVE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
